// File: rtl/link_master_fsm.sv
// Initiator side of the req/ack byte link: fetches bytes from a valid/ready source and sends
// each with a four-phase handshake. Optional ack timeout enabled by defining LINK_ACK_TIMEOUT_EN.
module link_master_fsm #(
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ack,
    output logic       req,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] sent_cnt,
    output logic       err,
    output logic [1:0] state_dbg
);

    // Handshakes: a source byte moves when tx_valid && tx_ready at a rising edge; a link byte is
    // offered while req is high and is complete once ack has been seen high and then low again.

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        FETCH        = 2'd1,
        REQ          = 2'd2,
        WAIT_ACK_LOW = 2'd3
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

    if ((BURST_LEN < 1) || (BURST_LEN > 255) || (TIMEOUT < 1)) begin : g_bad_param
        $error("link_master_fsm: BURST_LEN must be 1..255 and TIMEOUT at least 1");
    end

    state_t     state;
    state_t     state_nx;
    logic [7:0] data_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_nx;
    logic       done_q;
    logic       done_nx;
    logic       load_data;
    logic       req_timeout;

`ifdef LINK_ACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] to_cnt;
    logic          err_q;

    assign req_timeout = (state == REQ) && !ack && (to_cnt == TO_LAST);

    // Restarts on every entry to REQ so each byte gets the full TIMEOUT window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= req_timeout;
            if (load_data) begin
                to_cnt <= '0;
            end else if (state == REQ) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign req_timeout = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt_q;
        done_nx   = 1'b0;
        load_data = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = FETCH;
                    cnt_nx   = 8'd0;
                end
            end
            FETCH: begin
                if (tx_valid) begin
                    load_data = 1'b1;
                    state_nx  = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    state_nx = WAIT_ACK_LOW;
                end else if (req_timeout) begin
                    state_nx = IDLE;
                end
            end
            WAIT_ACK_LOW: begin
                if (!ack) begin
                    cnt_nx = cnt_q + 8'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = FETCH;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            data_q <= 8'd0;
            cnt_q  <= 8'd0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt_q  <= cnt_nx;
            done_q <= done_nx;
            if (load_data) begin
                data_q <= tx_data;
            end
        end
    end

    // Link-side outputs come from registers only, so reset drops req without a clock edge.
    assign req       = (state == REQ);
    assign tx_ready  = (state == FETCH);
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign data_out  = data_q;
    assign sent_cnt  = cnt_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_link_master_fsm.sv
// Directed bench for link_master_fsm with a behavioural link slave, a byte source and a
// scoreboard of expected link bytes. Timeout steps run when LINK_ACK_TIMEOUT_EN is defined.
module tb_link_master_fsm;

    localparam int BL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       ack = 1'b0;
    logic       tx_ready;
    logic       req;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic [7:0] sent_cnt;
    logic       err;
    logic [1:0] state_dbg;

    link_master_fsm #(.BURST_LEN(BL), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .ack(ack), .req(req), .data_out(data_out), .busy(busy),
        .done(done), .sent_cnt(sent_cnt), .err(err), .state_dbg(state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    logic [7:0] src_q[$];
    int         ack_delay = 1;
    int         ack_hold = 2;
    bit         slave_en = 1'b1;
    int         stall_left = 0;
    int         stall_idx = -1;
    int         src_sent = 0;
    int         bytes_acked = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         busy_cycles = 0;
    int         c0 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        src_q.push_back(b);
        exp_q.push_back(b);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (busy) busy_cycles++;
    end

    // ---------------- byte source ----------------
    initial begin
        bit acc;
        forever begin
            @(negedge clk);
            acc = 1'b0;
            if (!rst) begin
                tx_valid = 1'b0;
            end else begin
                if (tx_ready && stall_left > 0 && src_sent == stall_idx) begin
                    tx_valid = 1'b0;
                    stall_left--;
                    chk("stall_req_low", req, 0);
                end else if (src_q.size() > 0) begin
                    tx_valid = 1'b1;
                    tx_data  = src_q[0];
                end else begin
                    tx_valid = 1'b0;
                end
                acc = tx_valid && tx_ready;
            end
            @(posedge clk);
            if (acc && rst && src_q.size() > 0) begin
                void'(src_q.pop_front());
                src_sent++;
            end
        end
    end

    // ---------------- link slave ----------------
    initial begin
        int req_cnt;
        int hold_cnt;
        bit holding;
        req_cnt  = 0;
        hold_cnt = 0;
        holding  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                ack      = 1'b0;
                holding  = 1'b0;
                req_cnt  = 0;
                hold_cnt = 0;
            end else if (!slave_en) begin
                ack = 1'b0;
            end else if (!holding) begin
                if (req) begin
                    req_cnt++;
                    chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        chk("data_stable", data_out, exp_q[0]);
                        if (req_cnt > ack_delay) begin
                            ack      = 1'b1;
                            holding  = 1'b1;
                            hold_cnt = 0;
                            req_cnt  = 0;
                            chk("last_byte", data_out, exp_q.pop_front());
                            bytes_acked++;
                        end
                    end
                end
            end else begin
                hold_cnt++;
                chk("req_low_in_hold", req, 0);
                if (hold_cnt >= ack_hold) begin
                    ack     = 1'b0;
                    holding = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(posedge clk);
        #1;
        start       = 1'b1;
        c0          = cyc;
        done_cnt    = 0;
        busy_cycles = 0;
        src_sent    = 0;
        bytes_acked = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_burst(input string name, input int exp_delta, input bit dup_start);
        bit got;
        int delta;
        got   = 1'b0;
        delta = -1;
        pulse_start();
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (dup_start) start = (i == 7);
            if (done) begin
                got   = 1'b1;
                delta = cyc - c0;
            end
        end
        start = 1'b0;
        chk({name, "_done_seen"}, got, 1);
        chk({name, "_done_cycle"}, delta, exp_delta);
        repeat (3) @(negedge clk);
        chk({name, "_done_pulses"}, done_cnt, 1);
        chk({name, "_busy_cycles"}, busy_cycles, exp_delta - 1);
        chk({name, "_sent_cnt"}, sent_cnt, BL);
        chk({name, "_idle"}, busy, 0);
        chk({name, "_sb_drained"}, exp_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit got;
        int reqc;

        // Reset values
        #12;
        chk("rst_req", req, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_sent_cnt", sent_cnt, 0);
        chk("rst_state", state_dbg, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal burst, with a start pulse mid-burst that must be ignored
        push_byte(8'hA1);
        push_byte(8'hB2);
        push_byte(8'hC3);
        push_byte(8'hD4);
        run_burst("nominal", 5 * BL + 1, 1'b1);

        // Source stall of 7 cycles before byte 2
        for (int i = 0; i < BL; i++) push_byte(8'($urandom_range(0, 255)));
        stall_idx  = 1;
        stall_left = 7;
        run_burst("stall", 5 * BL + 1 + 7, 1'b0);
        chk("stall_consumed", stall_left, 0);
        stall_idx = -1;

        // Late ack: 5 extra REQ cycles per byte
        for (int i = 0; i < BL; i++) push_byte(8'($urandom_range(0, 255)));
        ack_delay = 6;
        run_burst("late_ack", 10 * BL + 1, 1'b0);
        ack_delay = 1;

        // Reset while in REQ of byte 2
        for (int i = 0; i < BL; i++) push_byte(8'($urandom_range(0, 255)));
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (req && bytes_acked == 1) got = 1'b1;
        end
        chk("mid_reach_req2", got, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_req_async", req, 0);
        chk("mid_busy_async", busy, 0);
        chk("mid_state_async", state_dbg, 0);
        repeat (2) @(negedge clk);
        src_q.delete();
        exp_q.delete();
        done_cnt = 0;
        #1;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_no_done", done_cnt, 0);
        chk("mid_sent_cnt", sent_cnt, 0);
        push_byte(8'h5A);
        for (int i = 1; i < BL; i++) push_byte(8'($urandom_range(0, 255)));
        run_burst("after_rst", 5 * BL + 1, 1'b0);

`ifdef LINK_ACK_TIMEOUT_EN
        // Timeout with ack tied low
        slave_en = 1'b0;
        src_q.push_back(8'h77);
        err_cnt = 0;
        pulse_start();
        got  = 1'b0;
        reqc = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (req) reqc++;
            if (err) got = 1'b1;
        end
        chk("to_err_seen", got, 1);
        chk("to_req_cycles", reqc, 16);
        chk("to_busy", busy, 0);
        chk("to_sent_cnt", sent_cnt, 0);
        @(negedge clk);
        chk("to_err_pulse", err, 0);
        chk("to_err_count", err_cnt, 1);
        chk("to_no_done", done_cnt, 0);
        src_q.delete();
        slave_en = 1'b1;
`else
        chk("err_never", err_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
